controller: RTL and testbench

CONTROLLER -- requirements
Module: controller

---
 rtl/controller_if.sv | 33 +++
 rtl/controller.sv | 180 ++++++++++++++++++
 tb/tb_controller.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/controller_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in,
// datapath/memory strobes and selects out.
interface controller_if;
  logic [5:0] i_op;
  logic [5:0] i_funct;
  logic       i_zero;
  logic       o_regwrite;
  logic       o_memtoreg;
  logic       o_regdst;
  logic       o_instrwrite;
  logic       o_PCen;
  logic       o_IorD;
  logic       o_AluSrcA;
  logic       o_memwrite;
  logic [1:0] o_PCsrc;
  logic [1:0] o_AluSrcB;
  logic [2:0] o_alucontrol;
  logic [3:0] o_state;

  // Datapath side: drives instruction fields, receives controls.
  modport master (
    output i_op, i_funct, i_zero,
    input  o_regwrite, o_memtoreg, o_regdst, o_instrwrite, o_PCen, o_IorD,
           o_AluSrcA, o_memwrite, o_PCsrc, o_AluSrcB, o_alucontrol, o_state
  );

  // Controller side.
  modport slave (
    input  i_op, i_funct, i_zero,
    output o_regwrite, o_memtoreg, o_regdst, o_instrwrite, o_PCen, o_IorD,
           o_AluSrcA, o_memwrite, o_PCsrc, o_AluSrcB, o_alucontrol, o_state
  );
endinterface

// File: rtl/controller.sv
// Multicycle MIPS-subset controller: Moore FSM (lw, sw, R-type, beq, addi, j).
// Outputs decode from the state register; write strobes are gated by reset
// so nothing can be written while reset is held.
module controller (
  input  logic      i_clk,
  input  logic      i_reset,
  controller_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q;
  state_t state_d;

  logic       regwrite_s;
  logic       memtoreg_s;
  logic       regdst_s;
  logic       instrwrite_s;
  logic       pcwrite_s;
  logic       branch_s;
  logic       iord_s;
  logic       alusrca_s;
  logic       memwrite_s;
  logic [1:0] pcsrc_s;
  logic [1:0] alusrcb_s;
  logic [2:0] alucontrol_s;
  logic [2:0] funct_alu_s;

  // Next-state logic; op is only looked at in DECODE and MEMADR.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (bus.i_op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (bus.i_op == OP_SW) begin
          state_d = MEMWR;
        end else if (bus.i_op == OP_LW) begin
          state_d = MEMRD;
        end else begin
          state_d = FETCH;
        end
      end
      MEMRD:    state_d = MEMWB;
      EXECUTE:  state_d = ALUWB;
      ADDIEXEC: state_d = ADDIWB;
      default:  state_d = FETCH;
    endcase
  end

  // State register; reset parks the machine in FETCH immediately.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // R-type function field to ALU operation; unknown functs default to add.
  always_comb begin
    funct_alu_s = 3'b010;
    case (bus.i_funct)
      6'b100000: funct_alu_s = 3'b010;
      6'b100010: funct_alu_s = 3'b110;
      6'b100100: funct_alu_s = 3'b000;
      6'b100101: funct_alu_s = 3'b001;
      6'b101010: funct_alu_s = 3'b111;
      default:   funct_alu_s = 3'b010;
    endcase
  end

  // Moore output decode; every control not named for a state stays 0.
  always_comb begin
    regwrite_s   = 1'b0;
    memtoreg_s   = 1'b0;
    regdst_s     = 1'b0;
    instrwrite_s = 1'b0;
    pcwrite_s    = 1'b0;
    branch_s     = 1'b0;
    iord_s       = 1'b0;
    alusrca_s    = 1'b0;
    memwrite_s   = 1'b0;
    pcsrc_s      = 2'b00;
    alusrcb_s    = 2'b00;
    alucontrol_s = 3'b000;
    case (state_q)
      FETCH: begin
        alusrcb_s    = 2'b01;
        alucontrol_s = 3'b010;
        instrwrite_s = 1'b1;
        pcwrite_s    = 1'b1;
      end
      DECODE: begin
        alusrcb_s    = 2'b11;
        alucontrol_s = 3'b010;
      end
      MEMADR, ADDIEXEC: begin
        alusrca_s    = 1'b1;
        alusrcb_s    = 2'b10;
        alucontrol_s = 3'b010;
      end
      MEMRD: iord_s = 1'b1;
      MEMWB: begin
        memtoreg_s = 1'b1;
        regwrite_s = 1'b1;
      end
      MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
      end
      EXECUTE: begin
        alusrca_s    = 1'b1;
        alucontrol_s = funct_alu_s;
      end
      ALUWB: begin
        regdst_s   = 1'b1;
        regwrite_s = 1'b1;
      end
      BRANCH: begin
        alusrca_s    = 1'b1;
        alucontrol_s = 3'b110;
        pcsrc_s      = 2'b01;
        branch_s     = 1'b1;
      end
      ADDIWB: regwrite_s = 1'b1;
      JUMP: begin
        pcsrc_s   = 2'b10;
        pcwrite_s = 1'b1;
      end
      default: begin
        regwrite_s = 1'b0;
      end
    endcase
  end

  // Write strobes are masked by reset so an abort can never write.
  assign bus.o_regwrite   = regwrite_s & i_reset;
  assign bus.o_memwrite   = memwrite_s & i_reset;
  assign bus.o_instrwrite = instrwrite_s & i_reset;
  assign bus.o_PCen       = (pcwrite_s | (branch_s & bus.i_zero)) & i_reset;
  assign bus.o_memtoreg   = memtoreg_s;
  assign bus.o_regdst     = regdst_s;
  assign bus.o_IorD       = iord_s;
  assign bus.o_AluSrcA    = alusrca_s;
  assign bus.o_PCsrc      = pcsrc_s;
  assign bus.o_AluSrcB    = alusrcb_s;
  assign bus.o_alucontrol = alucontrol_s;
  assign bus.o_state      = state_q;

endmodule

// File: tb/tb_controller.sv
// Bench for controller: random instruction stream with reference state paths
// and per-state control table, plus aborts by reset at every step.
module tb_controller;
  logic i_clk;
  logic i_reset;
  controller_if bus ();

  controller dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int nvec;
  int nerr;
  bit aligned;
  int seq[$];

  // Expected state path of one instruction, FETCH through its last state.
  function automatic void build_seq(input logic [5:0] op);
    seq.delete();
    seq.push_back(0);
    seq.push_back(1);
    case (op)
      6'b100011: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
      6'b101011: begin seq.push_back(2); seq.push_back(5); end
      6'b000000: begin seq.push_back(6); seq.push_back(7); end
      6'b000100: seq.push_back(8);
      6'b001000: begin seq.push_back(9); seq.push_back(10); end
      6'b000010: seq.push_back(11);
      default: ;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Control word {regwrite,memtoreg,regdst,instrwrite,PCen,IorD,AluSrcA,
  // memwrite,PCsrc,AluSrcB,alucontrol} expected in state st.
  function automatic logic [14:0] exp_ctrl(input int st, input logic [5:0] fn,
                                            input logic z);
    logic rw, mtr, rd, iw, pw, br, iord, sa, mw;
    logic [1:0] ps, sb;
    logic [2:0] alu;
    {rw, mtr, rd, iw, pw, br, iord, sa, mw} = 9'b0;
    ps = 2'b00; sb = 2'b00; alu = 3'b000;
    case (st)
      0:  begin sb = 2'b01; alu = 3'b010; iw = 1'b1; pw = 1'b1; end
      1:  begin sb = 2'b11; alu = 3'b010; end
      2:  begin sa = 1'b1; sb = 2'b10; alu = 3'b010; end
      3:  iord = 1'b1;
      4:  begin mtr = 1'b1; rw = 1'b1; end
      5:  begin iord = 1'b1; mw = 1'b1; end
      6:  begin sa = 1'b1; alu = alu_of(fn); end
      7:  begin rd = 1'b1; rw = 1'b1; end
      8:  begin sa = 1'b1; alu = 3'b110; ps = 2'b01; br = 1'b1; end
      9:  begin sa = 1'b1; sb = 2'b10; alu = 3'b010; end
      10: rw = 1'b1;
      11: begin ps = 2'b10; pw = 1'b1; end
      default: ;
    endcase
    return {rw, mtr, rd, iw, pw | (br & z), iord, sa, mw, ps, sb, alu};
  endfunction

  function automatic logic [14:0] obs_ctrl();
    return {bus.o_regwrite, bus.o_memtoreg, bus.o_regdst, bus.o_instrwrite,
            bus.o_PCen, bus.o_IorD, bus.o_AluSrcA, bus.o_memwrite,
            bus.o_PCsrc, bus.o_AluSrcB, bus.o_alucontrol};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Run one instruction; abort_at >= 0 asserts reset mid-cycle at that step.
  // zmode: 0/1 forces i_zero, anything else randomizes it each cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int abort_at, input int zmode);
    build_seq(op);
    for (int i = 0; i < seq.size(); i++) begin
      if (!(i == 0 && aligned)) @(negedge i_clk);
      aligned = 1'b0;
      if (seq[i] == 1 || seq[i] == 2 || seq[i] == 6) begin
        bus.i_op    = op;
        bus.i_funct = fn;
      end else begin
        bus.i_op    = 6'($urandom);
        bus.i_funct = 6'($urandom);
      end
      bus.i_zero = (zmode == 0 || zmode == 1) ? 1'(zmode) : 1'($urandom);
      if (i == abort_at) begin
        #2 i_reset = 1'b0;
        #1;
        check("abort_state", 32'(bus.o_state), 32'd0);
        check("abort_strobes",
              32'({bus.o_regwrite, bus.o_memwrite, bus.o_instrwrite, bus.o_PCen}),
              32'd0);
        @(negedge i_clk);
        check("held_state", 32'(bus.o_state), 32'd0);
        i_reset = 1'b1;
        aligned = 1'b1;
        return;
      end
      #1;
      check($sformatf("state op=%b step%0d", op, i), 32'(bus.o_state), 32'(seq[i]));
      check($sformatf("ctrl st%0d fn=%b z=%b", seq[i], fn, bus.i_zero),
            32'(obs_ctrl()), 32'(exp_ctrl(seq[i], fn, bus.i_zero)));
    end
  endtask

  function automatic logic [5:0] pick_op(input int k);
    logic [5:0] v;
    case (k)
      0: return 6'b100011;
      1: return 6'b101011;
      2: return 6'b000000;
      3: return 6'b000100;
      4: return 6'b001000;
      5: return 6'b000010;
      default: begin
        v = 6'($urandom);
        while (v == 6'b100011 || v == 6'b101011 || v == 6'b000000 ||
               v == 6'b000100 || v == 6'b001000 || v == 6'b000010)
          v = 6'($urandom);
        return v;
      end
    endcase
  endfunction

  function automatic logic [5:0] pick_fn();
    case ($urandom_range(0, 5))
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      4: return 6'b101010;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    logic [5:0] op;
    nvec = 0;
    nerr = 0;
    aligned = 1'b0;
    bus.i_op = 6'd0; bus.i_funct = 6'd0; bus.i_zero = 1'b0;
    i_reset = 1'b0;
    // Reset state while held.
    repeat (2) @(negedge i_clk);
    #1;
    check("reset_state", 32'(bus.o_state), 32'd0);
    check("reset_strobes",
          32'({bus.o_regwrite, bus.o_memwrite, bus.o_instrwrite, bus.o_PCen}), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b1;
    aligned = 1'b1;

    // Directed: lw, sw, slt, beq taken/not taken, illegal 111111.
    run_instr(6'b100011, 6'd0, -1, 2);
    run_instr(6'b101011, 6'd0, -1, 2);
    run_instr(6'b000000, 6'b101010, -1, 2);
    run_instr(6'b000100, 6'd0, -1, 1);
    run_instr(6'b000100, 6'd0, -1, 0);
    run_instr(6'b111111, 6'd0, -1, 2);

    // Random instruction stream.
    for (int n = 0; n < 200; n++) begin
      run_instr(pick_op($urandom_range(0, 6)), pick_fn(), -1, 2);
    end

    // Abort each instruction kind at every one of its steps.
    for (int k = 0; k < 7; k++) begin
      op = pick_op(k);
      build_seq(op);
      for (int a = 0; a < seq.size(); a++) begin
        run_instr(op, pick_fn(), a, 2);
        run_instr(pick_op($urandom_range(0, 6)), pick_fn(), -1, 2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
